// File: rtl/out_word_packer.sv
// out_word_packer
//   Packs byte-wide output writes from the bilinear core into 32-bit word
//   writes with byte enables, queued in a small FIFO toward the frame
//   buffer / DMA over a valid/ready interface. A flush pulse drains the
//   partial accumulator word and then reports completion with a 1-cycle pulse.
//
//   Parameters: AW (byte address width), DEPTH (word FIFO entries, power of 2).
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     i_we/i_waddr/i_wdata  byte write from the core
//     i_flush           end-of-frame pulse
//     o_word_valid/i_word_ready  word handshake (FIFO head)
//     o_word_addr/o_word_data/o_word_be  head word (little-endian lanes)
//     o_busy            accumulator or FIFO occupied, or flush in progress
//     o_flush_done      1-cycle pulse when the drain has completed
//     o_overflow        sticky: a byte or word was dropped
//   Optional build macro PACKER_STATS_EN adds o_word_count and
//   o_partial_count (words accepted into the FIFO / those with be != 4'hF).

module out_word_packer #(
    parameter int AW    = 19,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic          i_flush,
    output logic          o_word_valid,
    input  logic          i_word_ready,
    output logic [AW-3:0] o_word_addr,
    output logic [31:0]   o_word_data,
    output logic [3:0]    o_word_be,
    output logic          o_busy,
    output logic          o_flush_done,
    output logic          o_overflow
`ifdef PACKER_STATS_EN
    ,
    output logic [31:0]   o_word_count,
    output logic [31:0]   o_partial_count
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int WW = (AW - 2) + 32 + 4;
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_n;

    // accumulator
    logic          acc_valid, acc_valid_n;
    logic [AW-3:0] acc_addr, acc_addr_n;
    logic [31:0]   acc_data, acc_data_n;
    logic [3:0]    acc_be, acc_be_n;

    // word FIFO
    logic [WW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;

    logic          pop, space, push, push_ok, overflow_set;
    logic [WW-1:0] push_word;
    logic [1:0]    lane;
    logic [4:0]    shift;
    logic [3:0]    byte_be, merged_be;
    logic [31:0]   merged_data, byte_data;

    assign pop   = (count != '0) && i_word_ready;
    // a same-cycle pop frees a slot in a full FIFO
    assign space = (count != FULL_COUNT) || pop;

    assign lane      = i_waddr[1:0];
    assign shift     = {lane, 3'b000};
    assign byte_be   = 4'b0001 << lane;
    assign byte_data = {24'h0, i_wdata} << shift;
    // a repeat write to a lane overwrites that lane's data only
    assign merged_data = (acc_data & ~(32'h0000_00FF << shift)) | byte_data;
    assign merged_be   = acc_be | byte_be;

    always_comb begin
        state_n      = state;
        acc_valid_n  = acc_valid;
        acc_addr_n   = acc_addr;
        acc_data_n   = acc_data;
        acc_be_n     = acc_be;
        push         = 1'b0;
        push_word    = {acc_addr, acc_data, acc_be};
        overflow_set = 1'b0;
        o_flush_done = 1'b0;

        case (state)
            S_RUN: begin
                if (i_flush) state_n = S_DRAIN;
            end
            S_DRAIN: begin
                if (i_we) overflow_set = 1'b1;
                // the accumulator waits for space rather than being dropped
                if (acc_valid && space) begin
                    push        = 1'b1;
                    acc_valid_n = 1'b0;
                end
                if (!acc_valid && count == '0) state_n = S_DONE;
            end
            S_DONE: begin
                o_flush_done = 1'b1;
                state_n      = i_flush ? S_DRAIN : S_RUN;
            end
            default: state_n = S_RUN;
        endcase

        if (i_we && state != S_DRAIN) begin
            if (!acc_valid) begin
                acc_valid_n = 1'b1;
                acc_addr_n  = i_waddr[AW-1:2];
                acc_data_n  = byte_data;
                acc_be_n    = byte_be;
            end else if (acc_addr == i_waddr[AW-1:2]) begin
                if (merged_be == 4'hF) begin
                    push        = 1'b1;
                    push_word   = {acc_addr, merged_data, merged_be};
                    acc_valid_n = 1'b0;
                    acc_data_n  = '0;
                    acc_be_n    = '0;
                end else begin
                    acc_data_n = merged_data;
                    acc_be_n   = merged_be;
                end
            end else begin
                push        = 1'b1;
                acc_valid_n = 1'b1;
                acc_addr_n  = i_waddr[AW-1:2];
                acc_data_n  = byte_data;
                acc_be_n    = byte_be;
            end
        end

        if (push && !space) overflow_set = 1'b1;
    end

    assign push_ok = push && space;

    always_ff @(posedge clk) begin
        if (rst) state <= S_RUN;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_valid  <= 1'b0;
            acc_addr   <= '0;
            acc_data   <= '0;
            acc_be     <= '0;
            o_overflow <= 1'b0;
        end else begin
            acc_valid <= acc_valid_n;
            acc_addr  <= acc_addr_n;
            acc_data  <= acc_data_n;
            acc_be    <= acc_be_n;
            if (overflow_set) o_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_word;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign o_word_valid = (count != '0);
    assign {o_word_addr, o_word_data, o_word_be} = mem[rd_ptr];
    assign o_busy = acc_valid || (count != '0) || (state != S_RUN);

`ifdef PACKER_STATS_EN
    // totals are cleared by reset only, so a frame's counts survive its flush
    always_ff @(posedge clk) begin
        if (rst) begin
            o_word_count    <= '0;
            o_partial_count <= '0;
        end else if (push_ok) begin
            o_word_count <= o_word_count + 32'd1;
            if (push_word[3:0] != 4'hF) o_partial_count <= o_partial_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_out_word_packer.sv
// tb_out_word_packer
//   Directed self-checking bench for out_word_packer (AW=19, DEPTH=4).
//   Stimulus is driven 1 time unit after each rising edge; outputs are
//   checked at the same point, i.e. after the edge has settled.

module tb_out_word_packer;

    localparam int AW    = 19;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          we = 1'b0;
    logic [AW-1:0] waddr = '0;
    logic [7:0]    wdata = '0;
    logic          flush = 1'b0;
    logic          ready = 1'b0;
    logic          word_valid;
    logic [AW-3:0] word_addr;
    logic [31:0]   word_data;
    logic [3:0]    word_be;
    logic          busy, flush_done, overflow;
`ifdef PACKER_STATS_EN
    logic [31:0]   word_count, partial_count;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    out_word_packer #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_we         (we),
        .i_waddr      (waddr),
        .i_wdata      (wdata),
        .i_flush      (flush),
        .o_word_valid (word_valid),
        .i_word_ready (ready),
        .o_word_addr  (word_addr),
        .o_word_data  (word_data),
        .o_word_be    (word_be),
        .o_busy       (busy),
        .o_flush_done (flush_done),
        .o_overflow   (overflow)
`ifdef PACKER_STATS_EN
        ,
        .o_word_count    (word_count),
        .o_partial_count (partial_count)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic byte_wr(input int unsigned a, input logic [7:0] d);
        we    = 1'b1;
        waddr = AW'(a);
        wdata = d;
        step();
        we    = 1'b0;
    endtask

    task automatic check_head(input string tag, input int unsigned a, input logic [31:0] d,
                              input logic [3:0] be);
        check({tag, "_valid"}, 64'(word_valid), 64'(1'b1));
        check({tag, "_addr"}, 64'(word_addr), 64'(a));
        check({tag, "_data"}, 64'(word_data), 64'(d));
        check({tag, "_be"}, 64'(word_be), 64'(be));
    endtask

    initial begin
        logic [31:0] exp_data;

        // reset state
        step();
        step();
        check("rst_valid", 64'(word_valid), 64'(1'b0));
        check("rst_busy", 64'(busy), 64'(1'b0));
        check("rst_flush_done", 64'(flush_done), 64'(1'b0));
        check("rst_overflow", 64'(overflow), 64'(1'b0));
        check("rst_addr", 64'(word_addr), 64'(0));
        rst = 1'b0;

        // 1: full word, ready high
        ready = 1'b1;
        byte_wr(0, 8'h11);
        byte_wr(1, 8'h22);
        byte_wr(2, 8'h33);
        check("t1_not_yet", 64'(word_valid), 64'(1'b0));
        check("t1_busy_acc", 64'(busy), 64'(1'b1));
        byte_wr(3, 8'h44);
        check_head("t1_word", 0, 32'h4433_2211, 4'hF);
        step();
        check("t1_popped", 64'(word_valid), 64'(1'b0));
        check("t1_idle", 64'(busy), 64'(1'b0));

        // 2: partial words and flush
        ready = 1'b0;
        byte_wr(8, 8'h11);
        byte_wr(9, 8'h22);
        check("t2_held", 64'(word_valid), 64'(1'b0));
        byte_wr(20, 8'h33);
        check_head("t2_w2", 2, 32'h0000_2211, 4'h3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("t2_drain_busy", 64'(busy), 64'(1'b1));
        step();
        check("t2_no_pulse", 64'(flush_done), 64'(1'b0));
        ready = 1'b1;
        check_head("t2_w2_still", 2, 32'h0000_2211, 4'h3);
        step();
        check_head("t2_w5", 5, 32'h0000_0033, 4'h1);
        step();
        check("t2_empty", 64'(word_valid), 64'(1'b0));
        check("t2_pulse_early", 64'(flush_done), 64'(1'b0));
        check("t2_busy_draining", 64'(busy), 64'(1'b1));
        step();
        check("t2_pulse", 64'(flush_done), 64'(1'b1));
        step();
        check("t2_pulse_end", 64'(flush_done), 64'(1'b0));
        check("t2_busy_end", 64'(busy), 64'(1'b0));
`ifdef PACKER_STATS_EN
        check("t2_word_count", 64'(word_count), 64'(3));
        check("t2_partial_count", 64'(partial_count), 64'(2));
`endif

        // 3: backpressure, fill FIFO, one dropped word
        ready = 1'b0;
        for (int k = 0; k < 4 * DEPTH; k++) byte_wr(32'h100 + k, 8'(k + 1));
        check("t3_full_no_ovf", 64'(overflow), 64'(1'b0));
        for (int k = 4 * DEPTH; k < 4 * (DEPTH + 1); k++) byte_wr(32'h100 + k, 8'(k + 1));
        check("t3_overflow", 64'(overflow), 64'(1'b1));
        check("t3_busy", 64'(busy), 64'(1'b1));
        ready = 1'b1;
        for (int w = 0; w < DEPTH; w++) begin
            exp_data = {8'(4 * w + 4), 8'(4 * w + 3), 8'(4 * w + 2), 8'(4 * w + 1)};
            check_head($sformatf("t3_w%0d", w), 32'h40 + w, exp_data, 4'hF);
            step();
        end
        check("t3_drained", 64'(word_valid), 64'(1'b0));
        check("t3_ovf_sticky", 64'(overflow), 64'(1'b1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t3_ovf_cleared", 64'(overflow), 64'(1'b0));

        // 4: repeated lane write then flush
        byte_wr(6, 8'hAA);
        byte_wr(6, 8'hBB);
        check("t4_held", 64'(word_valid), 64'(1'b0));
        ready = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        check_head("t4_word", 1, 32'h00BB_0000, 4'b0100);
        ready = 1'b1;
        step();
        step();
        check("t4_pulse", 64'(flush_done), 64'(1'b1));
        step();
        check("t4_idle", 64'(busy), 64'(1'b0));

        // 5: empty flush, byte dropped during drain
        check("t5_ovf_start", 64'(overflow), 64'(1'b0));
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("t5_no_pulse_1", 64'(flush_done), 64'(1'b0));
        byte_wr(32'h30, 8'h55);
        check("t5_pulse_2", 64'(flush_done), 64'(1'b1));
        check("t5_overflow", 64'(overflow), 64'(1'b1));
        check("t5_nothing_queued", 64'(word_valid), 64'(1'b0));
        step();
        check("t5_pulse_gone", 64'(flush_done), 64'(1'b0));
        check("t5_idle", 64'(busy), 64'(1'b0));

        // 6: reset in the middle of a drain
        rst = 1'b1;
        step();
        rst = 1'b0;
        ready = 1'b0;
        for (int k = 0; k < 8; k++) byte_wr(k, 8'(8'hC0 + k));
        check_head("t6_head", 0, 32'hC3C2_C1C0, 4'hF);
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        check("t6_draining", 64'(busy), 64'(1'b1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_valid", 64'(word_valid), 64'(1'b0));
        check("t6_busy", 64'(busy), 64'(1'b0));
        check("t6_no_pulse", 64'(flush_done), 64'(1'b0));
        step();
        check("t6_no_pulse_later", 64'(flush_done), 64'(1'b0));
        check("t6_still_idle", 64'(busy), 64'(1'b0));
`ifdef PACKER_STATS_EN
        check("t6_word_count", 64'(word_count), 64'(0));
        check("t6_partial_count", 64'(partial_count), 64'(0));
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
